// File: rtl/if_fetch.sv
// Instruction fetch stage: keeps one instruction-memory request in flight and
// presents returned words on registered IF outputs, with a one-entry skid buffer.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_IF,
  input  logic        jmp_vld_IF,
  input  logic [31:0] jmp_addr_IF,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvld,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_pc,
  output logic [31:0] IF_inst,
  output logic        IF_inst_vld
);

  // state | meaning
  // IDLE  | no request in flight; also parked here while a stall blocks new fetches
  // REQ   | imem_req asserted at fetch_pc, waiting for imem_gnt
  // WAIT  | one request granted, waiting for its imem_rvld
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;
  logic [31:0] jmp_tgt;
  logic        skid_vld;
  logic        drop;
  logic        accept;
  logic        issue;
  logic        grant;

  assign jmp_tgt = jmp_addr_IF & 32'hFFFF_FFFC;
  assign accept  = (state == WAIT) && imem_rvld && !drop;

  // fetch_pc is always the next address to request, so a back-to-back issue
  // in the rvld cycle uses it unchanged.
  assign issue     = !rst && ((state == REQ) || (accept && !hold_IF && !jmp_vld_IF));
  assign grant     = issue && imem_gnt;
  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC & 32'hFFFF_FFFC;
      req_pc      <= RESET_PC & 32'hFFFF_FFFC;
      drop        <= 1'b0;
      skid_vld    <= 1'b0;
      skid_pc     <= RESET_PC;
      skid_inst   <= NOP_INST;
      IF_pc       <= RESET_PC;
      IF_inst     <= NOP_INST;
      IF_inst_vld <= 1'b0;
    end else begin
      if (jmp_vld_IF) begin
        fetch_pc <= jmp_tgt;
      end else if (grant) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (grant) begin
        req_pc <= fetch_pc;
      end

      case (state)
        IDLE: begin
          if (jmp_vld_IF || !hold_IF) state <= REQ;
        end
        REQ: begin
          // a grant in the jump cycle was for the old address: its data must be dropped
          if (grant) begin
            state <= WAIT;
            drop  <= jmp_vld_IF;
          end
        end
        WAIT: begin
          if (imem_rvld) begin
            drop <= 1'b0;
            if (grant) begin
              state <= WAIT;
            end else if (hold_IF && !jmp_vld_IF) begin
              state <= IDLE;
            end else begin
              state <= REQ;
            end
          end else if (jmp_vld_IF) begin
            drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (jmp_vld_IF) begin
        IF_inst     <= NOP_INST;
        IF_inst_vld <= 1'b0;
        skid_vld    <= 1'b0;
      end else if (hold_IF) begin
        if (accept) begin
          skid_vld  <= 1'b1;
          skid_pc   <= req_pc;
          skid_inst <= imem_rdata;
        end
      end else if (skid_vld) begin
        IF_pc       <= skid_pc;
        IF_inst     <= skid_inst;
        IF_inst_vld <= 1'b1;
        skid_vld    <= accept;
        if (accept) begin
          skid_pc   <= req_pc;
          skid_inst <= imem_rdata;
        end
      end else if (accept) begin
        IF_pc       <= req_pc;
        IF_inst     <= imem_rdata;
        IF_inst_vld <= 1'b1;
      end else begin
        IF_inst     <= NOP_INST;
        IF_inst_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a queue-based memory and instruction-stream
// model checks every cycle; directed scenarios pin the cycle-exact behaviour.
module tb_if_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold_IF = 1'b0;
  logic        jmp_vld_IF = 1'b0;
  logic [31:0] jmp_addr_IF = '0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvld = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] IF_pc;
  logic [31:0] IF_inst;
  logic        IF_inst_vld;

  if_fetch dut (
    .clk(clk), .rst(rst), .hold_IF(hold_IF), .jmp_vld_IF(jmp_vld_IF),
    .jmp_addr_IF(jmp_addr_IF), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvld(imem_rvld), .imem_rdata(imem_rdata),
    .IF_pc(IF_pc), .IF_inst(IF_inst), .IF_inst_vld(IF_inst_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          lat;
    bit          stale;
    bit          orphan;
  } req_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } out_t;

  req_t pend[$];
  out_t skid[$];
  int n_tests = 0;
  int n_fail = 0;
  int n_deliv = 0;
  bit armed = 0;
  bit g_last = 0;
  logic [31:0] want_pc = RESET_PC;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_inst = NOP;
  logic        exp_vld = 1'b0;
  logic        s_req, s_vld;
  logic [31:0] s_addr, s_pc, s_inst;

  function automatic logic [31:0] word_of(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, check request side, advance model.
  task automatic cyc(bit r, bit h, bit j, logic [31:0] ja, bit g, int lat);
    bit   got;
    bit   deliv;
    req_t e;
    out_t d;
    @(negedge clk);
    s_vld = IF_inst_vld; s_pc = IF_pc; s_inst = IF_inst;
    if (armed) begin
      chk("if_vld", 32'(s_vld), 32'(exp_vld));
      chk("if_pc", s_pc, exp_pc);
      chk("if_inst", s_inst, exp_inst);
    end
    rst = r; hold_IF = h; jmp_vld_IF = j; jmp_addr_IF = ja; imem_gnt = g;
    got = (pend.size() > 0) && (pend[0].lat == 0);
    imem_rvld = got;
    imem_rdata = got ? word_of(pend[0].addr) : $urandom;
    #1;
    s_req = imem_req; s_addr = imem_addr;
    if (r) begin
      chk("req_in_rst", 32'(s_req), 0);
    end else begin
      if (s_req) begin
        chk("req_addr", s_addr, want_pc);
        chk("one_outstanding", 32'((pend.size() == 0) || got || pend[0].orphan), 1);
      end
      if (got && !pend[0].stale && !h && !j) chk("b2b_req", 32'(s_req), 1);
    end
    g_last = !r && s_req && g;
    deliv = 0;
    if (got) begin
      e = pend.pop_front();
      deliv = !e.stale && !j && !r;
    end else if (pend.size() > 0) begin
      pend[0].lat = pend[0].lat - 1;
    end
    if (r) begin
      foreach (pend[i]) begin pend[i].stale = 1; pend[i].orphan = 1; end
      skid.delete();
      want_pc = RESET_PC; exp_vld = 0; exp_pc = RESET_PC; exp_inst = NOP;
      armed = 1;
    end else begin
      if (g_last) begin
        pend.push_back('{want_pc, lat, 1'b0, 1'b0});
        want_pc = want_pc + 32'd4;
      end
      if (j) begin
        foreach (pend[i]) pend[i].stale = 1;
        want_pc = {ja[31:2], 2'b00};
        skid.delete();
        exp_vld = 0; exp_inst = NOP;
      end else if (h) begin
        if (deliv) begin
          skid.push_back('{e.addr, word_of(e.addr)});
          chk("skid_depth", 32'(skid.size()), 1);
        end
      end else begin
        if (deliv) skid.push_back('{e.addr, word_of(e.addr)});
        if (skid.size() > 0) begin
          d = skid.pop_front();
          exp_vld = 1; exp_pc = d.pc; exp_inst = d.inst;
          n_deliv++;
        end else begin
          exp_vld = 0; exp_inst = NOP;
        end
      end
    end
  endtask

  task automatic go(int lat);
    cyc(0, 0, 0, 32'h0, 1, lat);
  endtask

  task automatic wait_vld(string tag, logic [31:0] pc);
    bit found = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      go(0);
      found = s_vld;
    end
    chk({tag, "_seen"}, 32'(found), 1);
    if (found) chk(tag, s_pc, pc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int d0;

    // reset release, zero-wait memory
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_vld", 32'(s_vld), 0);
    chk("rst_pc", s_pc, RESET_PC);
    chk("rst_inst", s_inst, NOP);
    go(0); chk("k1_no_req", 32'(s_req), 0);
    go(0); chk("k2_req", 32'(s_req), 1); chk("k2_addr", s_addr, RESET_PC);
    go(0);
    go(0); chk("zw_pc0", s_pc, 32'h0); chk("zw_vld0", 32'(s_vld), 1);
    go(0); chk("zw_pc4", s_pc, 32'h4); chk("zw_vld4", 32'(s_vld), 1);
    go(0); chk("zw_pc8", s_pc, 32'h8); chk("zw_vld8", 32'(s_vld), 1);
    chk("zw_inst8", s_inst, word_of(32'h8));

    // one-cycle hold while 0x8's word returns
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) go(0);
    cyc(0, 1, 0, 0, 1, 0); chk("hold_pc_before", s_pc, 32'h4);
    go(0); chk("hold_frozen_pc", s_pc, 32'h4); chk("hold_frozen_vld", 32'(s_vld), 1);
    go(0); chk("skid_pc", s_pc, 32'h8); chk("skid_inst", s_inst, word_of(32'h8));

    // jump while the 0x10 request is outstanding
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      go(2);
      found = (pend.size() > 0) && (pend[pend.size()-1].addr == 32'h10) && g_last;
    end
    chk("wait_0x10_seen", 32'(found), 1);
    cyc(0, 0, 1, 32'h100, 1, 0);
    go(0); chk("jmp_vld", 32'(s_vld), 0); chk("jmp_inst", s_inst, NOP);
    wait_vld("jmp_target", 32'h100);

    // jump and hold together: jump wins, target aligned
    cyc(0, 1, 1, 32'h203, 1, 0);
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (i == 0) chk("jh_vld", 32'(s_vld), 0);
      found = s_req;
    end
    chk("jh_req_seen", 32'(found), 1);
    if (found) chk("jh_addr", s_addr, 32'h200);
    wait_vld("jh_target", 32'h200);

    // address wrap
    cyc(0, 0, 1, 32'hFFFF_FFFC, 1, 0);
    wait_vld("wrap_top", 32'hFFFF_FFFC);
    wait_vld("wrap_zero", 32'h0);

    // reset in the middle of an outstanding request, memory slow afterwards
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      go(3);
      found = g_last;
    end
    chk("mid_grant_seen", 32'(found), 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0); chk("mr_k1_req", 32'(s_req), 0); chk("mr_k1_vld", 32'(s_vld), 0);
    cyc(0, 0, 0, 0, 0, 0); chk("mr_k2_req", 32'(s_req), 1); chk("mr_k2_addr", s_addr, RESET_PC);
    cyc(0, 0, 0, 0, 0, 0); chk("mr_k3_req", 32'(s_req), 1); chk("mr_k3_addr", s_addr, RESET_PC);
    go(0); chk("mr_stale_vld", 32'(s_vld), 0);
    wait_vld("mr_first", RESET_PC);

    // randomized traffic against the model
    d0 = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      bit h, j, g;
      logic [31:0] ja;
      h = ($urandom % 8) == 0;
      j = ($urandom % 20) == 0;
      g = ($urandom % 4) != 0;
      ja = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : ($urandom % 1024);
      cyc(0, h, j, ja, g, int'($urandom % 3));
    end
    chk("liveness", 32'((n_deliv - d0) > 300), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
